// File: rtl/adc_frame_packer.sv
// adc_frame_packer: captures one multi-channel ADC conversion per strobe and
// serialises it as a frame of 32-bit words for the write side of a FIFO.
// Frame layout: one header word, then NCHAN data words, plus an XOR check
// word when the ADC_FRAME_CRC_EN macro is defined.
//
// Ports:
//   clk          bus clock
//   srst         synchronous reset, active-high
//   stream_open  the packer runs only while this is high
//   smp_strobe   single-cycle pulse: smp_data holds a complete conversion
//   smp_data     NCHAN*SMP_W bits, channel k in [k*SMP_W +: SMP_W]
//   fifo_din     FIFO write data, combinational from the registered state
//   fifo_wr_en   FIFO write enable, combinational
//   fifo_full    FIFO full flag
//   busy         a captured frame is held and not yet fully written
//   drop_count   number of dropped frames, saturating
//
// Build option: ADC_FRAME_CRC_EN adds the CHECK state and its XOR accumulator.
module adc_frame_packer #(
  parameter int unsigned NCHAN = 8,
  parameter int unsigned SMP_W = 24
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   stream_open,
  input  logic                   smp_strobe,
  input  logic [NCHAN*SMP_W-1:0] smp_data,
  output logic [31:0]            fifo_din,
  output logic                   fifo_wr_en,
  input  logic                   fifo_full,
  output logic                   busy,
  output logic [15:0]            drop_count
);

  localparam int unsigned DATA_W = NCHAN * SMP_W;

`ifdef ADC_FRAME_CRC_EN
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_cap;
  logic [7:0]         r_ch;
  logic [7:0]         r_seq;
  logic [7:0]         r_dsh;
  logic [15:0]        r_drop_cnt;
  logic               r_busy;
`ifdef ADC_FRAME_CRC_EN
  logic [31:0]        r_crc;
`endif

  logic               w_wr_en;
  logic               w_start;
  logic               w_drop;
  logic               w_abort;
  logic               w_last;
  logic               w_hdr_wr;
  logic               w_data_wr;
  logic [SMP_W-1:0]   w_sample;
  logic [31:0]        w_hdr;
  logic [31:0]        w_din;

  // Strobe handling and the write qualifier; srst suppresses any write in its own cycle.
  assign w_wr_en   = (r_state != S_IDLE) & stream_open & ~fifo_full & ~srst;
  assign w_start   = (r_state == S_IDLE) & smp_strobe & stream_open;
  assign w_drop    = smp_strobe & ((r_state != S_IDLE) | ~stream_open);
  assign w_abort   = (r_state != S_IDLE) & ~stream_open;
  assign w_last    = (r_ch == 8'(NCHAN - 1));
  assign w_hdr_wr  = (r_state == S_HEADER) & w_wr_en;
  assign w_data_wr = (r_state == S_DATA) & w_wr_en;

  assign w_sample  = r_cap[int'(r_ch) * SMP_W +: SMP_W];
  assign w_hdr     = {8'hA5, r_seq, r_dsh, 8'(NCHAN)};

  // Next-state logic; a closed stream aborts the frame from any state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_HEADER;
      S_HEADER: if (w_wr_en) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_wr_en && w_last) begin
`ifdef ADC_FRAME_CRC_EN
          w_state_nxt = S_CHECK;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef ADC_FRAME_CRC_EN
      S_CHECK:  if (w_wr_en) w_state_nxt = S_IDLE;
`endif
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // Output word mux; holds naturally while stalled because the state holds.
  always_comb begin
    w_din = '0;
    case (r_state)
      S_HEADER: w_din = w_hdr;
      S_DATA:   w_din = {r_ch, 24'(w_sample)};
`ifdef ADC_FRAME_CRC_EN
      S_CHECK:  w_din = r_crc;
`endif
      default:  w_din = '0;
    endcase
  end

  assign fifo_din   = w_din;
  assign fifo_wr_en = w_wr_en;
  assign busy       = r_busy;
  assign drop_count = r_drop_cnt;

  // State, capture buffer, channel index and counters.
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state    <= S_IDLE;
      r_cap      <= '0;
      r_ch       <= '0;
      r_seq      <= '0;
      r_dsh      <= '0;
      r_drop_cnt <= '0;
      r_busy     <= 1'b0;
`ifdef ADC_FRAME_CRC_EN
      r_crc      <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);

      if (w_start) r_cap <= smp_data;

      if (w_hdr_wr)       r_ch <= '0;
      else if (w_data_wr) r_ch <= r_ch + 8'd1;

      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;

      // A drop coinciding with the header write is charged to the next header.
      if (w_abort) begin
        r_seq <= '0;
        r_dsh <= '0;
      end else if (w_hdr_wr) begin
        r_seq <= r_seq + 8'd1;
        r_dsh <= w_drop ? 8'd1 : 8'd0;
      end else if (w_drop && (r_dsh != 8'hFF)) begin
        r_dsh <= r_dsh + 8'd1;
      end

`ifdef ADC_FRAME_CRC_EN
      if (w_hdr_wr)       r_crc <= w_hdr;
      else if (w_data_wr) r_crc <= r_crc ^ w_din;
`endif
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Testbench for adc_frame_packer: directed scenarios plus random traffic,
// compared cycle by cycle against a frame-level reference model.
module tb_adc_frame_packer;

  localparam int unsigned NCHAN = 8;
  localparam int unsigned SMP_W = 24;
`ifdef ADC_FRAME_CRC_EN
  localparam bit CRC = 1'b1;
`else
  localparam bit CRC = 1'b0;
`endif

  logic                   clk;
  logic                   srst;
  logic                   stream_open;
  logic                   smp_strobe;
  logic [NCHAN*SMP_W-1:0] smp_data;
  logic [31:0]            fifo_din;
  logic                   fifo_wr_en;
  logic                   fifo_full;
  logic                   busy;
  logic [15:0]            drop_count;

  adc_frame_packer #(.NCHAN(NCHAN), .SMP_W(SMP_W)) dut (
    .clk         (clk),
    .srst        (srst),
    .stream_open (stream_open),
    .smp_strobe  (smp_strobe),
    .smp_data    (smp_data),
    .fifo_din    (fifo_din),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of words still owed to the FIFO.
  bit          m_active;
  bit          m_hdr_pend;
  bit          m_crc_pend;
  logic [31:0] m_words[$];
  logic [31:0] m_acc;
  int          m_seq;
  int          m_dsh;
  int          m_drops;
  logic [31:0] m_last_hdr;

  task automatic model_reset();
    m_active   = 1'b0;
    m_hdr_pend = 1'b0;
    m_crc_pend = 1'b0;
    m_words.delete();
    m_acc      = '0;
    m_seq      = 0;
    m_dsh      = 0;
    m_drops    = 0;
  endtask

  // Check this cycle's outputs, then apply the effect of the coming clock edge.
  task automatic model_step();
    bit          exp_we;
    bit          drop;
    bit          hdr_wr;
    logic [31:0] exp_din;
    logic [SMP_W-1:0] smp;

    exp_we = !srst && m_active && stream_open && !fifo_full;
    if (m_hdr_pend)            exp_din = {8'hA5, 8'(m_seq), 8'(m_dsh), 8'(NCHAN)};
    else if (m_words.size() > 0) exp_din = m_words[0];
    else                       exp_din = m_acc;

    check("wr_en", 32'(fifo_wr_en), 32'(exp_we));
    if (exp_we && fifo_wr_en) check("din", fifo_din, exp_din);
    check("busy", 32'(busy), 32'(m_active));
    check("drop_count", 32'(drop_count), 32'(m_drops));

    if (srst) begin
      model_reset();
      return;
    end

    drop   = smp_strobe && (m_active || !stream_open);
    hdr_wr = exp_we && m_hdr_pend;
    if (drop && m_drops < 65535) m_drops++;

    if (m_active && !stream_open) begin
      m_active = 1'b0;
      m_hdr_pend = 1'b0;
      m_crc_pend = 1'b0;
      m_words.delete();
      m_seq = 0;
      m_dsh = 0;
    end else begin
      if (hdr_wr) begin
        m_last_hdr = exp_din;
        m_acc      = exp_din;
        m_hdr_pend = 1'b0;
        m_seq      = (m_seq + 1) % 256;
        m_dsh      = drop ? 1 : 0;
      end else if (drop && m_dsh < 255) begin
        m_dsh++;
      end
      if (exp_we && !hdr_wr) begin
        if (m_words.size() > 0) begin
          m_acc = m_acc ^ m_words.pop_front();
          if (m_words.size() == 0 && !m_crc_pend) m_active = 1'b0;
        end else begin
          m_crc_pend = 1'b0;
          m_active   = 1'b0;
        end
      end
      if (!m_active && !drop && smp_strobe && stream_open && !(exp_we)) begin
        m_active   = 1'b1;
        m_hdr_pend = 1'b1;
        m_crc_pend = CRC;
        for (int k = 0; k < int'(NCHAN); k++) begin
          smp = smp_data[k*SMP_W +: SMP_W];
          m_words.push_back({8'(k), 24'(smp)});
        end
      end
    end
  endtask

  task automatic step(input bit strb, input bit opn, input bit ful, input bit rst);
    smp_strobe  = strb;
    stream_open = opn;
    fifo_full   = ful;
    srst        = rst;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic rand_data();
    for (int k = 0; k < int'(NCHAN); k++) smp_data[k*SMP_W +: SMP_W] = SMP_W'($urandom);
  endtask

  initial begin
    smp_data = '0;
    m_last_hdr = '0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_din", fifo_din, 32'h0);

    // Single frame with known channel values, then a drop 3 cycles later.
    for (int k = 0; k < int'(NCHAN); k++) smp_data[k*SMP_W +: SMP_W] = SMP_W'(24'h100000 + k);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("first_hdr", m_last_hdr, 32'hA5A5A5A5 & 32'h0);
    idle(2);
    check("first_hdr_lit", m_last_hdr, 32'hA5000008);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(10);
    check("drop1", 32'(drop_count), 32'd1);

    // Next frame carries seq=1 and one drop, and stalls for 5 cycles after data word 2.
    rand_data();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);
    check("hdr_after_drop", m_last_hdr, 32'hA5010108);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(10);

    // Close the stream after the 4th data word, then reopen: seq restarts.
    rand_data();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(12);
    check("hdr_reopen", m_last_hdr, 32'hA5000008);

    // Random traffic with stalls, stream closes and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rand_data();
      step($urandom_range(0, 5) == 0, $urandom_range(0, 60) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 700) == 0);
    end
    idle(20);

    // Saturate both drop counters while a frame is held by a full FIFO.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    rand_data();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 66000; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check("sat_count", 32'(drop_count), 32'h0000FFFF);
    idle(12);
    rand_data();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(12);
    check("sat_hdr_field", 32'(m_last_hdr[15:8]), 32'h000000FF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_frame_packer.md
Name: adc_frame_packer

Overview:
Upstream feeder for the 32-bit read stream: captures one multi-channel ADC conversion per strobe and serialises it into the write side of the 32-bit FIFO (fifo_32x512) drained by /dev/xillybus_read_32. Each frame is one header word followed by NCHAN data words. Frames arriving while a frame is still being emitted are dropped and counted. FIFO back-pressure stalls emission without data loss. Runs entirely on bus_clk.

Parameters:
NCHAN, 8, channels per frame; legal range 1..255.
SMP_W, 24, ADC sample width in bits; legal range 1..24.

Ports:
clk  in  1  bus_clk.
srst  in  1  synchronous reset, active-high.
stream_open  in  1  tied to user_r_read_32_open; packer is enabled only while high.
smp_strobe  in  1  single-cycle pulse: smp_data holds a complete conversion.
smp_data  in  NCHAN*SMP_W  channel k in bits [k*SMP_W +: SMP_W].
fifo_din  out  32  FIFO write data.
fifo_wr_en  out  1  FIFO write enable.
fifo_full  in  1  FIFO full flag.
busy  out  1  frame capture held and not yet fully written.
drop_count  out  16  total dropped frames, saturating.

Behaviour:
- Reset: on srst, state=IDLE; busy=0; fifo_wr_en=0; fifo_din=0; drop_count=0; seq=0; drop_since_hdr=0; capture buffer=0.
- States: IDLE, HEADER, DATA. With ADC_FRAME_CRC_EN, a fourth state CHECK follows DATA.
- IDLE to HEADER: smp_strobe=1 and stream_open=1. The full smp_data vector is latched into the capture buffer on that edge. busy=1 from the next cycle.
- Write rule: fifo_wr_en = (state != IDLE) & stream_open & !fifo_full, combinational from registered state and inputs. A word is consumed only on a cycle with fifo_wr_en=1. Otherwise state and fifo_din hold.
- Latency: strobe at cycle N gives the header on fifo_din/fifo_wr_en at cycle N+1 if not full.
- Header word: [31:24]=8'hA5; [23:16]=seq; [15:8]=drop_since_hdr; [7:0]=NCHAN.
- On header write: seq increments and wraps 255 to 0. drop_since_hdr clears to 0. If a drop occurs in the same cycle, drop_since_hdr is set to 1 instead of 0.
- HEADER to DATA on header write. Channel index ch starts at 0.
- Data word ch: [31:24]=ch; [23:0]=sample zero-extended from SMP_W. ch increments on each write.
- After the write of ch=NCHAN-1: go to IDLE (or CHECK when CHECK is compiled in). busy=0 on the following cycle.
- Drop: smp_strobe=1 while state != IDLE, or while stream_open=0.
  - drop_count increments and saturates at 16'hFFFF.
  - drop_since_hdr increments and saturates at 8'hFF.
  - The in-flight frame is unaffected.
  - A strobe in the cycle of the last data write is dropped. Minimum strobe spacing without loss is NCHAN+2 cycles (NCHAN+3 with CHECK).
- stream_open low in any non-IDLE state:
  - Frame is aborted; state=IDLE next cycle.
  - fifo_wr_en is 0 in that same cycle.
  - seq and drop_since_hdr reset to 0; drop_count is retained.
- srst mid-frame: abort immediately; all registers return to reset values. No partial-word write after reset.
- fifo_full asserted for any length mid-frame: output stalls and resumes with the same word. No duplication, no skip.

Optional Feature:
ADC_FRAME_CRC_EN
- Defined:
  - A running XOR of the header and all data words is accumulated as they are written. It is cleared when the header is written.
  - State CHECK emits the XOR result as one extra word, obeying the same write rule, then goes to IDLE.
  - Header bit [7:0] remains NCHAN; the trailer is implied by the build.
- Not defined: no CHECK state and no accumulator logic. The frame is exactly NCHAN+1 words.

Test Plan:
- NCHAN=8, SMP_W=24, fifo_full=0, one strobe with channel k = 24'h100000+k -> 9 consecutive writes starting 1 cycle after the strobe: 32'hA5000008, then 32'h00100000 through 32'h07100007; busy high for 9 cycles.
- Second strobe arriving 3 cycles after the first -> drop_count=1; the next frame's header is 32'hA5010108.
- fifo_full held high for 5 cycles after the 3rd data word -> no writes during the stall, then resume with ch=3. Total frame is exactly 9 writes in order.
- stream_open dropped after the 4th data word -> fifo_wr_en=0 from that cycle and state=IDLE. Reopen and strobe -> header 32'hA5000008 (seq restarted).
- 70000 strobes during a held frame (fifo_full=1) -> drop_count=16'hFFFF and header drop field=8'hFF.
- With ADC_FRAME_CRC_EN, the single frame from the first test -> 10th word equals the XOR of the previous 9 words.
